// File: rtl/commu_pkg.sv
// commu_pkg: shared frame constants, receiver FSM states and counter helpers
// for the commu serial link (transmitter and receiver).
package commu_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam int   CNT_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } commu_state_e;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/commu_baud_nco.sv
// commu_baud_nco: phase accumulator that emits one tick per bit period.
// A load strobe presets the phase; the receiver presets half a period.
module commu_baud_nco #(
  parameter int CLK_KHZ = 100000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic [15:0] inc,
  output logic        tick
);

  localparam logic [31:0] MODULUS = 32'(CLK_KHZ);

  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [31:0] sum;

  always_comb begin
    sum   = acc_q + {16'd0, inc};
    acc_d = acc_q;
    tick  = 1'b0;
    if (load) begin
      acc_d = load_val;
    end else if (en) begin
      if (sum >= MODULUS) begin
        acc_d = sum - MODULUS;
        tick  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/commu_rx.sv
// commu_rx: 8N1 serial receiver with good-frame and error counters.
// Optional payload sequence checker enabled by macro COMMU_RX_SEQ_CHK_EN.
module commu_rx
  import commu_pkg::*;
#(
  parameter int CLK_KHZ  = 100000,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [15:0]      tbit_fre,
  output logic [7:0]       rx_data,
  output logic             rx_vld,
  output logic             frm_err,
  output logic [CNT_W-1:0] rx_total,
  output logic [CNT_W-1:0] err_total
);

  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [31:0] HALF_BIT = 32'(CLK_KHZ / 2);

  logic [SYNC_LEN-1:0]  sync_q, sync_d;
  logic                 rxs_prev_q;
  commu_state_e         state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_vld_q, rx_vld_d;
  logic                 frm_err_q, frm_err_d;
  logic [CNT_W-1:0]     rx_total_q, rx_total_d;
`ifdef COMMU_RX_SEQ_CHK_EN
  logic [CNT_W-1:0]     err_total_q, err_total_d;
  logic [7:0]           exp_q, exp_d;
`endif

  logic rxs;
  logic fall;
  logic tick;
  logic nco_load;
  logic nco_en;
  logic good;
  logic bad_stop;

  commu_baud_nco #(
    .CLK_KHZ (CLK_KHZ)
  ) u_nco (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .en       (nco_en),
    .load     (nco_load),
    .load_val (HALF_BIT),
    .inc      (tbit_fre),
    .tick     (tick)
  );

  always_comb begin
    sync_d     = {sync_q[SYNC_LEN-2:0], rx};
    rxs        = sync_q[SYNC_LEN-1];
    fall       = rxs_prev_q & ~rxs;
    nco_load   = (state_q == IDLE) && fall;
    nco_en     = (state_q != IDLE);
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    good       = 1'b0;
    bad_stop   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (tick) begin
          if (rxs == START_LVL) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs == STOP_LVL) begin
            good    = 1'b1;
            state_d = IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs == STOP_LVL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rx_vld_d   = good;
    frm_err_d  = bad_stop;
    rx_data_d  = good ? shift_q : rx_data_q;
    rx_total_d = rx_total_q;
`ifdef COMMU_RX_SEQ_CHK_EN
    err_total_d = err_total_q;
    exp_d       = exp_q;
    if (good) begin
      if (shift_q == exp_q) rx_total_d = sat_inc(rx_total_q);
      else err_total_d = sat_inc(err_total_q);
      exp_d = shift_q + 8'd1;
    end
`else
    if (good) rx_total_d = sat_inc(rx_total_q);
`endif
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      rxs_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_vld_q    <= 1'b0;
      frm_err_q   <= 1'b0;
      rx_total_q  <= '0;
`ifdef COMMU_RX_SEQ_CHK_EN
      err_total_q <= '0;
      exp_q       <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      rxs_prev_q  <= rxs;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_vld_q    <= rx_vld_d;
      frm_err_q   <= frm_err_d;
      rx_total_q  <= rx_total_d;
`ifdef COMMU_RX_SEQ_CHK_EN
      err_total_q <= err_total_d;
      exp_q       <= exp_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_vld   = rx_vld_q;
  assign frm_err  = frm_err_q;
  assign rx_total = rx_total_q;
`ifdef COMMU_RX_SEQ_CHK_EN
  assign err_total = err_total_q;
`else
  assign err_total = '0;
`endif

endmodule
